// File: rtl/brick_hit_unit.sv
// -----------------------------------------------------------------------------
// brick_hit_unit
//
// Owns the live brick map during play. While the game is in its load state the
// map and its total hit points are captured from the level loader every cycle.
// During play, single hit requests from the collision logic are accepted,
// registered and resolved one cycle later. The acknowledged result, score
// increment and updated map appear on registered outputs one cycle after that.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-low reset
//   state [2:0]  game state: 1 = load, 2 = play, anything else = hold
//   brick_in     level map from the loader (0 = empty, 1..3 = strength)
//   hit_req      hit request valid
//   hit_idx      index of the struck brick
//   hit_ready    a request is accepted in this cycle when hit_req is high
//   hit_ack      one-cycle pulse, hit_result/score_add valid
//   hit_result   0 = empty slot, 1 = damaged, 2 = destroyed
//   score_add    score increment, zero when hit_ack is low
//   brick_out    registered live map for render and collision
//   hp_left      sum of all live brick strengths
//   level_clear  sticky, set when no hit points remain in play
// -----------------------------------------------------------------------------
module brick_hit_unit #(
   parameter  int NUM_BRICKS    = 64,
   parameter  int HP_W          = 8,
   parameter  int SCORE_DAMAGE  = 1,
   parameter  int SCORE_DESTROY = 4,
   localparam int IDX_W         = $clog2(NUM_BRICKS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       state,
   input  logic [1:0]       brick_in [NUM_BRICKS],
   input  logic             hit_req,
   input  logic [IDX_W-1:0] hit_idx,
   output logic             hit_ready,
   output logic             hit_ack,
   output logic [1:0]       hit_result,
   output logic [3:0]       score_add,
   output logic [1:0]       brick_out [NUM_BRICKS],
   output logic [HP_W-1:0]  hp_left,
   output logic             level_clear
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_PLAY,
      S_PEND
   } fsm_e;

   typedef enum logic [1:0] {
      RES_EMPTY     = 2'd0,
      RES_DAMAGED   = 2'd1,
      RES_DESTROYED = 2'd2
   } result_e;

   localparam logic [2:0] GS_LOAD = 3'd1;
   localparam logic [2:0] GS_PLAY = 3'd2;

   fsm_e             fsm_q, fsm_d;
   logic             loaded_q, loaded_d;     // a load has happened since reset
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [1:0]       brick_q [NUM_BRICKS];
   logic [1:0]       brick_d [NUM_BRICKS];
   logic [HP_W-1:0]  hp_q, hp_d;
   logic             clear_q, clear_d;
   logic             ack_q, ack_d;
   result_e          result_q, result_d;
   logic [3:0]       score_q, score_d;

   logic [HP_W-1:0]  load_sum;
   logic             in_range;
   logic [1:0]       strength;

   // Total hit points of the incoming map, each strength zero-extended.
   always_comb begin
      load_sum = '0;
      for (int i = 0; i < NUM_BRICKS; i++) begin
         load_sum = load_sum + HP_W'(brick_in[i]);
      end
   end

   // Indices beyond the map read as an empty slot.
   assign in_range = (32'(idx_q) < 32'(NUM_BRICKS));
   assign strength = in_range ? brick_q[idx_q] : 2'd0;

   assign hit_ready = (fsm_q == S_PLAY) && (state == GS_PLAY) && !clear_q;

   always_comb begin
      // NOTE: every variable gets a default before any branch so that no path
      // leaves it unassigned; a missing default would infer a latch.
      fsm_d    = fsm_q;
      loaded_d = loaded_q;
      idx_d    = idx_q;
      brick_d  = brick_q;
      hp_d     = hp_q;
      clear_d  = clear_q;
      ack_d    = 1'b0;
      result_d = RES_EMPTY;
      score_d  = '0;

      // Datapath actions of the current state.
      case (fsm_q)
         S_LOAD: begin
            brick_d  = brick_in;
            hp_d     = load_sum;
            clear_d  = 1'b0;
            loaded_d = 1'b1;
         end
         S_PLAY: begin
            if (hit_req && hit_ready) idx_d = hit_idx;
         end
         S_PEND: begin
            // Leaving play while pending drops the request: no ack, no update.
            if (state == GS_PLAY) begin
               ack_d = 1'b1;
               if (strength != 2'd0) begin
                  brick_d[idx_q] = strength - 2'd1;
                  hp_d           = (hp_q == '0) ? '0 : hp_q - 1'b1;
                  if (strength == 2'd1) begin
                     result_d = RES_DESTROYED;
                     score_d  = 4'(SCORE_DESTROY);
                  end else begin
                     result_d = RES_DAMAGED;
                     score_d  = 4'(SCORE_DAMAGE);
                  end
                  if (hp_d == '0) clear_d = 1'b1;
               end
            end
         end
         default: ;
      endcase

      // Next-state logic; a load request overrides everything.
      case (fsm_q)
         S_IDLE:  if (state == GS_PLAY && loaded_q) fsm_d = S_PLAY;
         S_LOAD:  fsm_d = (state == GS_PLAY) ? S_PLAY : S_IDLE;
         S_PLAY: begin
            if (state != GS_PLAY)          fsm_d = S_IDLE;
            else if (hit_req && hit_ready) fsm_d = S_PEND;
         end
         S_PEND:  fsm_d = (state == GS_PLAY) ? S_PLAY : S_IDLE;
         default: fsm_d = S_IDLE;
      endcase
      if (state == GS_LOAD) fsm_d = S_LOAD;

      // Entering play with nothing left to hit flags the level clear at once,
      // so hit_ready is already low on the first play cycle.
      if (fsm_d == S_PLAY && (fsm_q == S_IDLE || fsm_q == S_LOAD) && hp_d == '0)
         clear_d = 1'b1;
   end

   // NOTE: the brick map is a small register array, not a RAM macro, so it is
   // reset along with the rest of the state; that gives render a clean map.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q    <= S_IDLE;
         loaded_q <= 1'b0;
         idx_q    <= '0;
         for (int i = 0; i < NUM_BRICKS; i++) brick_q[i] <= 2'd0;
         hp_q     <= '0;
         clear_q  <= 1'b0;
         ack_q    <= 1'b0;
         result_q <= RES_EMPTY;
         score_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         fsm_q    <= fsm_d;
         loaded_q <= loaded_d;
         idx_q    <= idx_d;
         brick_q  <= brick_d;
         hp_q     <= hp_d;
         clear_q  <= clear_d;
         ack_q    <= ack_d;
         result_q <= result_d;
         score_q  <= score_d;
      end
   end

   assign hit_ack     = ack_q;
   assign hit_result  = result_q;
   assign score_add   = score_q;
   assign brick_out   = brick_q;
   assign hp_left     = hp_q;
   assign level_clear = clear_q;

endmodule

// File: tb/tb_brick_hit_unit.sv
// -----------------------------------------------------------------------------
// tb_brick_hit_unit
//
// Directed bench for brick_hit_unit. Inputs change 1 ns after the rising edge
// and outputs are sampled at that same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_brick_hit_unit;

   localparam int NB = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] state;
   logic [1:0] brick_in [NB];
   logic       hit_req;
   logic [5:0] hit_idx;
   logic       hit_ready;
   logic       hit_ack;
   logic [1:0] hit_result;
   logic [3:0] score_add;
   logic [1:0] brick_out [NB];
   logic [7:0] hp_left;
   logic       level_clear;

   int n_checks = 0;
   int n_fail   = 0;

   brick_hit_unit dut (
      .clk         (clk),
      .rst         (rst),
      .state       (state),
      .brick_in    (brick_in),
      .hit_req     (hit_req),
      .hit_idx     (hit_idx),
      .hit_ready   (hit_ready),
      .hit_ack     (hit_ack),
      .hit_result  (hit_result),
      .score_add   (score_add),
      .brick_out   (brick_out),
      .hp_left     (hp_left),
      .level_clear (level_clear)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare the whole live map against an expected map, one comparison.
   task automatic check_map(input string tag, input logic [1:0] exp [NB]);
      int bad = 0;
      for (int i = 0; i < NB; i++) if (brick_out[i] !== exp[i]) bad++;
      check(tag, bad, 0);
   endtask

   // Load the map currently on brick_in for n cycles of state=1, then play.
   task automatic load_and_play(input int n);
      state = 3'd1;
      repeat (n) tick();
      state = 3'd2;
      tick();
   endtask

   // One accepted hit: ready now, no ack in PEND, ack with results after.
   task automatic do_hit(input string tag, input int idx, input int res, input int sc,
                         input int brick, input int hp);
      check({tag, "_ready"}, hit_ready, 1);
      hit_req = 1'b1;
      hit_idx = 6'(idx);
      tick();
      hit_req = 1'b0;
      check({tag, "_noack_pend"}, hit_ack, 0);
      tick();
      check({tag, "_ack"},    hit_ack, 1);
      check({tag, "_result"}, hit_result, 32'(res));
      check({tag, "_score"},  score_add, 32'(sc));
      check({tag, "_brick"},  brick_out[idx], 32'(brick));
      check({tag, "_hp"},     hp_left, 32'(hp));
   endtask

   logic [1:0] exp_map [NB];

   initial begin
      rst     = 1'b0;
      state   = 3'd0;
      hit_req = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < NB; i++) brick_in[i] = 2'd0;
      #1;
      for (int i = 0; i < NB; i++) exp_map[i] = 2'd0;
      check_map("rst_map", exp_map);
      check("rst_hp",    hp_left, 0);
      check("rst_clear", level_clear, 0);
      check("rst_ready", hit_ready, 0);
      check("rst_ack",   hit_ack, 0);
      check("rst_score", score_add, 0);
      tick();
      rst = 1'b1;

      // Play without a prior load stays idle.
      state = 3'd2;
      repeat (3) tick();
      check("noload_ready", hit_ready, 0);

      // Pattern 32 x 1, 32 x 2, loaded for three cycles.
      for (int i = 0; i < NB; i++) brick_in[i] = (i < 32) ? 2'd1 : 2'd2;
      for (int i = 0; i < NB; i++) exp_map[i] = (i < 32) ? 2'd1 : 2'd2;
      load_and_play(3);
      check_map("pat_map", exp_map);
      check("pat_hp",    hp_left, 96);
      check("pat_ready", hit_ready, 1);
      check("pat_clear", level_clear, 0);

      // Reset while a hit is pending.
      hit_req = 1'b1;
      hit_idx = 6'd40;
      tick();
      hit_req = 1'b0;
      rst = 1'b0;
      #1;
      for (int i = 0; i < NB; i++) exp_map[i] = 2'd0;
      check_map("rstpend_map", exp_map);
      check("rstpend_hp",    hp_left, 0);
      check("rstpend_ready", hit_ready, 0);
      tick();
      check("rstpend_noack", hit_ack, 0);
      state = 3'd0;
      rst   = 1'b1;
      tick();

      // All-3 map; three hits on brick 5.
      for (int i = 0; i < NB; i++) brick_in[i] = 2'd3;
      load_and_play(2);
      check("all3_hp", hp_left, 192);
      do_hit("h5a", 5, 1, 1, 2, 191);
      do_hit("h5b", 5, 1, 1, 1, 190);
      do_hit("h5c", 5, 2, 4, 0, 189);
      tick();
      check("h5_ackpulse", hit_ack, 0);
      check("h5_score0",   score_add, 0);

      // Empty slot 60 in an otherwise all-3 map.
      brick_in[60] = 2'd0;
      load_and_play(1);
      check("empty_hp_load", hp_left, 189);
      do_hit("h60", 60, 0, 0, 0, 189);

      // Single brick of strength 1.
      for (int i = 0; i < NB; i++) brick_in[i] = 2'd0;
      brick_in[10] = 2'd1;
      load_and_play(1);
      check("one_hp", hp_left, 1);
      check("one_clear_pre", level_clear, 0);
      do_hit("h10", 10, 2, 4, 0, 0);
      check("one_clear", level_clear, 1);
      check("one_ready", hit_ready, 0);
      hit_req = 1'b1;
      hit_idx = 6'd10;
      repeat (3) tick();
      hit_req = 1'b0;
      check("one_ignored_ack", hit_ack, 0);
      check("one_sticky", level_clear, 1);
      for (int i = 0; i < NB; i++) brick_in[i] = 2'd3;
      state = 3'd1;
      tick();
      tick();
      check("reload_clear", level_clear, 0);
      state = 3'd2;
      tick();
      check("reload_hp",    hp_left, 192);
      check("reload_ready", hit_ready, 1);

      // Leave play while a hit on brick 3 is pending.
      hit_req = 1'b1;
      hit_idx = 6'd3;
      tick();
      hit_req = 1'b0;
      state   = 3'd4;
      tick();
      check("drop_noack", hit_ack, 0);
      check("drop_brick", brick_out[3], 3);
      check("drop_hp",    hp_left, 192);
      check("drop_ready", hit_ready, 0);
      state = 3'd2;
      tick();
      check("drop_ready_back", hit_ready, 1);
      check("drop_noack_back", hit_ack, 0);

      // Loading an empty map clears the level on the first play cycle.
      for (int i = 0; i < NB; i++) brick_in[i] = 2'd0;
      load_and_play(1);
      check("zero_clear", level_clear, 1);
      check("zero_ready", hit_ready, 0);
      check("zero_hp",    hp_left, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/brick_hit_unit.md
Name: brick_hit_unit

Overview:
- Owns the live brick map during play: captures the per-level brick pattern written by the level loader, then services single hit requests from the ball/collision logic.
- Each hit decrements the struck brick's strength, reports the result and score increment, tracks remaining hit points and flags level clear.
- Sits between the level loader (writer of the initial map) and the collision/score/render logic (consumers of the live map).

Parameters:
- NUM_BRICKS, 64: number of brick slots; index width is $clog2(NUM_BRICKS).
- HP_W, 8: width of the hit-point counter; sized for NUM_BRICKS*3 (192 fits in 8 bits).
- SCORE_DAMAGE, 1: score increment for a hit that leaves the brick alive.
- SCORE_DESTROY, 4: score increment for a hit that drops the brick to 0.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous active-low reset.
- state, input, 3: game state. 1 = load, 2 = play, any other value = hold.
- brick_in, input, 2 x NUM_BRICKS (unpacked): level map from the loader. Value 0 means empty; 1-3 is strength.
- hit_req, input, 1: hit request valid.
- hit_idx, input, 6: index of the brick hit.
- hit_ready, output, 1: unit can accept a request this cycle.
- hit_ack, output, 1: one-cycle pulse; the result is valid in this cycle.
- hit_result, output, 2: 0 = empty slot, 1 = damaged, 2 = destroyed.
- score_add, output, 4: score increment, valid with hit_ack; 0 otherwise.
- brick_out, output, 2 x NUM_BRICKS (unpacked): registered live map for render and collision.
- hp_left, output, HP_W: sum of all live brick strengths.
- level_clear, output, 1: sticky flag, set when no hit points remain in play.

Behaviour:
- Reset (rst=0, any time, asynchronous):
  - brick_out all 0, hp_left=0, level_clear=0.
  - hit_ready=0, hit_ack=0, hit_result=0, score_add=0.
  - FSM goes to IDLE and any pending request is discarded.
- FSM states: IDLE, LOAD, PLAY, PEND.
  - Any state -> LOAD whenever state==1. This has priority over everything else.
  - LOAD -> PLAY when state==2. LOAD -> IDLE for any other value of state.
  - IDLE -> PLAY when state==2, but only if a load has happened since reset. Otherwise the FSM stays in IDLE.
  - PLAY -> PEND when hit_req && hit_ready. The index is registered in this cycle.
  - PEND -> PLAY on the next cycle; the hit is processed and acked in that cycle.
  - PLAY or PEND -> IDLE when state is neither 1 nor 2. A pending request is dropped with no ack and the map is unchanged.
- LOAD:
  - Every cycle: brick_out <= brick_in, hp_left <= sum of all brick_in values (zero-extended to HP_W), level_clear <= 0.
  - The last loaded cycle wins.
- hit_ready:
  - Equals 1 only in PLAY with state==2 and level_clear==0.
  - Combinational from FSM state and registered flags.
- Hit processing in the PEND cycle (outputs registered, so hit_ack is high the cycle after PEND, i.e. 2 cycles after acceptance):
  - If s = brick_out[idx] == 0: hit_result=0, score_add=0, no state change.
  - If s > 1: brick_out[idx] <= s-1, hp_left <= hp_left-1, hit_result=1, score_add=SCORE_DAMAGE.
  - If s == 1: brick_out[idx] <= 0, hp_left <= hp_left-1, hit_result=2, score_add=SCORE_DESTROY.
  - hp_left saturates at 0 and never underflows.
- Requester protocol:
  - Holds hit_req and hit_idx until hit_ready is sampled high.
  - Must not issue a new request before hit_ack.
  - hit_req while hit_ready=0 is ignored and not queued.
- level_clear:
  - Set in the same cycle hp_left is written to 0 while in PEND.
  - Also set on the first PLAY cycle if hp_left==0 on entry.
  - Cleared only by LOAD or reset.
- Out-of-range index (idx >= NUM_BRICKS): treated as an empty slot (result 0), no state change.
- brick_out and hp_left hold their values in IDLE and PLAY; they are modified only by LOAD and PEND.

Test Plan:
- Reset mid-PEND -> no hit_ack; brick_out all 0; hp_left=0; hit_ready=0.
- state=1 with pattern "32 slots of 1, 32 slots of 2" for 3 cycles, then state=2 -> brick_out matches the pattern; hp_left=96; hit_ready=1 on the first PLAY cycle.
- Load all-3 map (hp_left=192); hit idx 5 three times -> results 1,1,2; score_add 1,1,4; brick_out[5] goes 2,1,0; hp_left=189; each hit_ack arrives 2 cycles after acceptance.
- Hit an empty slot (brick_out[60]=0) -> hit_result=0, score_add=0, hp_left unchanged, hit_ack still pulses.
- Map with one brick of strength 1 (hp_left=1); hit it -> hit_result=2; hp_left=0; level_clear=1; hit_ready=0; level_clear persists until state=1 -> level_clear=0.
- Accept hit idx 3, then state=4 in the PEND cycle -> no hit_ack; brick_out[3] unchanged; FSM in IDLE; return to state=2 -> hit_ready=1.
